// File: rtl/l2_cpi_response_queue.sv
// CPI response queue between the L2 response stage and the L1 response port.
// Optional same-cycle bypass when empty is enabled by defining L2_CPI_QUEUE_BYPASS_EN.
module l2_cpi_response_queue #(
    parameter int DEPTH = 4,
    parameter int SLACK = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cpi_valid,
    input  logic         cpi_status,
    input  logic [1:0]   cpi_unit,
    input  logic [1:0]   cpi_strand,
    input  logic [1:0]   cpi_op,
    input  logic         cpi_update,
    input  logic [1:0]   cpi_way,
    input  logic [511:0] cpi_data,
    output logic         almost_full,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_status,
    output logic [1:0]   rsp_unit,
    output logic [1:0]   rsp_strand,
    output logic [1:0]   rsp_op,
    output logic         rsp_update,
    output logic [1:0]   rsp_way,
    output logic [511:0] rsp_data,
    output logic         overflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int EW = 1 + 2 + 2 + 2 + 1 + 2 + 512;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LEVEL = CW'(DEPTH - SLACK);

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          almost_full_q, almost_full_d;
    logic          overflow_q, overflow_d;

    logic [EW-1:0] in_entry;
    logic [EW-1:0] head_entry;
    logic [EW-1:0] out_entry;
    logic          stored_vld;
    logic          full;
    logic          push;
    logic          pop;
    logic          bypass;

    assign in_entry   = {cpi_status, cpi_unit, cpi_strand, cpi_op, cpi_update, cpi_way, cpi_data};
    assign head_entry = mem_q[rptr_q];
    assign stored_vld = (count_q != '0);
    assign full       = (count_q == DEPTH_C);
    assign pop        = stored_vld && rsp_ready;

`ifdef L2_CPI_QUEUE_BYPASS_EN
    // An empty queue with a ready consumer hands the response straight through.
    assign bypass = !stored_vld && cpi_valid && rsp_ready;
`else
    assign bypass = 1'b0;
`endif

    // A pop in the same cycle frees the slot, so a full queue can still accept.
    assign push = cpi_valid && !bypass && (!full || pop);

    always_comb begin
        rptr_d        = rptr_q + AW'(pop);
        wptr_d        = wptr_q + AW'(push);
        count_d       = count_q + CW'(push) - CW'(pop);
        overflow_d    = overflow_q || (cpi_valid && full && !pop);
        almost_full_d = (count_d >= AF_LEVEL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rptr_q        <= '0;
            wptr_q        <= '0;
            count_q       <= '0;
            almost_full_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            rptr_q        <= rptr_d;
            wptr_q        <= wptr_d;
            count_q       <= count_d;
            almost_full_q <= almost_full_d;
            overflow_q    <= overflow_d;
        end
    end

    // Payload storage carries no reset; empty slots are masked at the output.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem_q[wptr_q] <= in_entry;
        end
    end

    always_comb begin
        out_entry = '0;
        if (stored_vld) begin
            out_entry = head_entry;
        end else if (bypass) begin
            out_entry = in_entry;
        end
    end

    assign rsp_valid   = stored_vld || bypass;
    assign almost_full = almost_full_q;
    assign overflow    = overflow_q;
    assign {rsp_status, rsp_unit, rsp_strand, rsp_op, rsp_update, rsp_way, rsp_data} = out_entry;

endmodule

// File: tb/tb_l2_cpi_response_queue.sv
// Directed scoreboard bench for l2_cpi_response_queue (DEPTH=4, SLACK=2).
// Follows L2_CPI_QUEUE_BYPASS_EN the same way the design does.
module tb_l2_cpi_response_queue;

    localparam int DEPTH = 4;
    localparam int SLACK = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         cpi_valid;
    logic         cpi_status;
    logic [1:0]   cpi_unit;
    logic [1:0]   cpi_strand;
    logic [1:0]   cpi_op;
    logic         cpi_update;
    logic [1:0]   cpi_way;
    logic [511:0] cpi_data;
    logic         almost_full;
    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_status;
    logic [1:0]   rsp_unit;
    logic [1:0]   rsp_strand;
    logic [1:0]   rsp_op;
    logic         rsp_update;
    logic [1:0]   rsp_way;
    logic [511:0] rsp_data;
    logic         overflow;

    l2_cpi_response_queue #(.DEPTH(DEPTH), .SLACK(SLACK)) dut (
        .clk(clk), .reset(reset), .cpi_valid(cpi_valid),
        .cpi_status(cpi_status), .cpi_unit(cpi_unit), .cpi_strand(cpi_strand),
        .cpi_op(cpi_op), .cpi_update(cpi_update), .cpi_way(cpi_way), .cpi_data(cpi_data),
        .almost_full(almost_full), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_status(rsp_status), .rsp_unit(rsp_unit), .rsp_strand(rsp_strand),
        .rsp_op(rsp_op), .rsp_update(rsp_update), .rsp_way(rsp_way), .rsp_data(rsp_data),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [521:0] sb[$];
    logic exp_af = 1'b0;
    logic exp_ovf = 1'b0;
`ifdef L2_CPI_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    function automatic logic [521:0] mk(input logic st, input logic [1:0] un, input logic [1:0] sd,
                                        input logic [1:0] op, input logic up, input logic [1:0] wy,
                                        input logic [7:0] pat);
        logic [511:0] d;
        d = {64{pat}};
        return {st, un, sd, op, up, wy, d};
    endfunction

    task automatic chk(input string tag, input logic [521:0] obs, input logic [521:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [521:0] rsp_vec();
        return {rsp_status, rsp_unit, rsp_strand, rsp_op, rsp_update, rsp_way, rsp_data};
    endfunction

    // One clock of stimulus; entered and left 1ns after a rising edge.
    task automatic step(input string tag, input logic v, input logic [521:0] e, input logic rdy);
        logic was_full;
        logic popped;
        logic byp;
        {cpi_status, cpi_unit, cpi_strand, cpi_op, cpi_update, cpi_way, cpi_data} = e;
        cpi_valid = v;
        rsp_ready = rdy;
        #1;
        byp = BYP && v && rdy && (sb.size() == 0);
        chk({tag, ".rsp_valid"}, 522'(rsp_valid), 522'((sb.size() != 0) || byp));
        if (sb.size() != 0) chk({tag, ".head"}, rsp_vec(), sb[0]);
        else if (byp) chk({tag, ".bypass"}, rsp_vec(), e);
        was_full = (sb.size() == DEPTH);
        popped = (sb.size() != 0) && rdy;
        if (popped) void'(sb.pop_front());
        if (v && !byp && (!was_full || popped)) sb.push_back(e);
        if (v && was_full && !popped) exp_ovf = 1'b1;
        exp_af = (sb.size() >= DEPTH - SLACK);
        @(posedge clk);
        #1;
        cpi_valid = 1'b0;
        rsp_ready = 1'b0;
        chk({tag, ".almost_full"}, 522'(almost_full), 522'(exp_af));
        chk({tag, ".overflow"}, 522'(overflow), 522'(exp_ovf));
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        cpi_valid = 1'b1;
        cpi_data = {64{8'hEE}};
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cpi_valid = 1'b0;
        sb.delete();
        exp_af = 1'b0;
        exp_ovf = 1'b0;
        chk({tag, ".rsp_valid"}, 522'(rsp_valid), 522'(0));
        chk({tag, ".almost_full"}, 522'(almost_full), 522'(0));
        chk({tag, ".overflow"}, 522'(overflow), 522'(0));
        chk({tag, ".rsp_fields"}, rsp_vec(), 522'(0));
    endtask

    logic [521:0] idle;
    logic [521:0] nw;

    initial begin
        idle = '0;
        reset = 1'b1;
        cpi_valid = 1'b0;
        rsp_ready = 1'b0;
        {cpi_status, cpi_unit, cpi_strand, cpi_op, cpi_update, cpi_way, cpi_data} = '0;
        repeat (2) @(posedge clk);
        #1;
        do_reset("por");

        // Reset mid-operation discards everything in flight.
        step("mid_push0", 1'b1, mk(1, 1, 0, 1, 0, 1, 8'hA1), 1'b0);
        step("mid_push1", 1'b1, mk(0, 1, 1, 2, 1, 2, 8'hA2), 1'b0);
        step("mid_push2", 1'b1, mk(1, 3, 2, 1, 1, 3, 8'hA3), 1'b0);
        do_reset("mid_reset");
        step("after_rst_push", 1'b1, mk(0, 2, 1, 1, 0, 0, 8'hB2), 1'b0);
        step("after_rst_pop", 1'b0, idle, 1'b1);
        step("after_rst_empty", 1'b0, idle, 1'b0);

        // Ordering across pointer wrap.
        step("ord_push11", 1'b1, mk(0, 0, 0, 1, 0, 0, 8'h11), 1'b0);
        step("ord_push22", 1'b1, mk(1, 1, 1, 2, 0, 1, 8'h22), 1'b0);
        step("ord_push33", 1'b1, mk(0, 2, 2, 1, 1, 2, 8'h33), 1'b0);
        step("ord_pop0", 1'b0, idle, 1'b1);
        step("ord_pop1", 1'b0, idle, 1'b1);
        step("ord_push44", 1'b1, mk(1, 3, 3, 2, 1, 3, 8'h44), 1'b0);
        step("ord_push55", 1'b1, mk(0, 1, 2, 1, 0, 1, 8'h55), 1'b0);
        for (int i = 0; i < 3; i++) step("ord_drain", 1'b0, idle, 1'b1);
        step("ord_empty", 1'b0, idle, 1'b1);

        // almost_full assertion and release timing.
        step("af_push1", 1'b1, mk(0, 0, 1, 1, 0, 2, 8'h61), 1'b0);
        step("af_push2", 1'b1, mk(1, 2, 0, 2, 1, 1, 8'h62), 1'b0);
        step("af_hold", 1'b0, idle, 1'b0);
        step("af_pop1", 1'b0, idle, 1'b1);
        step("af_pop2", 1'b0, idle, 1'b1);

        // Full queue with simultaneous push and pop.
        for (int i = 0; i < DEPTH; i++) step("full_fill", 1'b1, mk(1'(i), 2'(i), 2'(i + 1), 1, 0, 2'(i), 8'(8'h70 + i)), 1'b0);
        nw = mk(1, 3, 3, 2, 1, 3, 8'h7F);
        step("full_pushpop", 1'b1, nw, 1'b1);
        for (int i = 0; i < DEPTH; i++) step("full_drain", 1'b0, idle, 1'b1);
        chk("full_last_gone", 522'(sb.size()), 522'(0));

        // Overflow: drop while full, then drain the originals.
        for (int i = 0; i < DEPTH; i++) step("ovf_fill", 1'b1, mk(0, 2'(i), 1, 2, 1'(i), 1, 8'(8'h80 + i)), 1'b0);
        step("ovf_drop", 1'b1, mk(1, 1, 3, 1, 1, 0, 8'hDD), 1'b0);
        step("ovf_hold", 1'b0, idle, 1'b0);
        for (int i = 0; i < DEPTH; i++) step("ovf_drain", 1'b0, idle, 1'b1);

        // Empty queue, push with consumer ready.
        step("byp_push", 1'b1, mk(0, 1, 2, 1, 0, 3, 8'hC5), 1'b1);
        step("byp_next", 1'b0, idle, 1'b1);
        step("byp_idle", 1'b0, idle, 1'b0);

        do_reset("final_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
